proc_hier_top: RTL and testbench
================================

// Module: proc_hier_top
// PURPOSE
//  Observability top of the 16-bit pipelined processor hierarchy. It sits beside core p0 inside proc_hier.
//  Qualifies raw core/cache status into architectural trace events: reg write, load, store, cache req/hit, halt.
//  Keeps the cycle counter, a fetch-stall history shifter and optional performance counters for sim logging.
// PARAMETERS
//  CNT_W   32  width of cycle_count and every performance counter
//  HIST_D  10  depth of fetch-stall history shift register
// PORTS
//  clk              in   1   single system clock; all state on rising edge
//  rst              in   1   asynchronous, active-low reset (0 = reset asserted)
//  pc_in, inst_in   in   16  fetch PC / fetched instruction from p0
//  wb_reg_write     in   1   WB-stage register-write enable (raw)
//  wb_write_reg     in   3   WB destination register
//  wb_write_data    in   16  WB write data
//  id_fetch_stall   in   1   fetch stall as latched into ID
//  wb_mem_stall     in   1   mem stall as latched into WB
//  fetch_stall      in   1   live instruction-fetch stall
//  mem_stall        in   1   live data-memory stall
//  m_mem_read/m_mem_write in 1 MEM-stage access requests (raw)
//  m_addr, m_wdata, m_rdata in 16 MEM address, store data, load data
//  icache_hit_in, dcache_hit_in in 1 cache hit strobes
//  proc_halt        in   1   HALT reached MEM/WB
//  pc, inst         out  16  trace copies of pc_in / inst_in
//  reg_write        out  1   qualified register write
//  write_reg/write_data out 3/16 passthrough of WB fields
//  mem_read/mem_write out 1  qualified load / store
//  mem_addr, mem_data_in, mem_data_out out 16 passthrough of m_addr, m_wdata, m_rdata
//  icache_req, icache_hit, dcache_req, dcache_hit out 1 cache event strobes
//  halt             out  1   passthrough of proc_halt
//  cycle_count      out  CNT_W cycles since reset release
//  fetch_stall_hist out  HIST_D fetch-stall history, bit HIST_D-1 newest
// BEHAVIOUR
//  All event outputs combinational, zero latency:
//   reg_write  = wb_reg_write & ~id_fetch_stall & ~wb_mem_stall
//   mem_read   = m_mem_read  & ~mem_stall & ~fetch_stall; mem_write likewise with m_mem_write
//   icache_req = ~fetch_stall; icache_hit = icache_hit_in; dcache_hit = dcache_hit_in
//   dcache_req = ~mem_stall & (m_mem_read | m_mem_write)
//  Both stalls high: mem_read = mem_write = 0; dcache_req still obeys its own equation.
//  fetch_stall_hist <= {fetch_stall, fetch_stall_hist[HIST_D-1:1]} every cycle.
//  halted: sticky flag, set on cycle after halt=1; cleared only by reset.
//  cycle_count: +1 per cycle while !halted. Includes halt cycle, then freezes. Wraps modulo 2^CNT_W.
//  Reset (rst=0, async): cycle_count, fetch_stall_hist, halted, all counters -> 0.
//   Combinational outputs follow inputs during reset.
//   Mid-run reset clears everything immediately. Counting resumes first edge after rst=1.
// CONFIGURATION
//  PROC_PERF_CNT_EN defined: extra CNT_W outputs inst_count, icache_hit_cnt, icache_req_cnt, dcache_hit_cnt, dcache_req_cnt.
//   inst_count +1 on each edge where halt|reg_write|mem_write.
//   Others +1 on their strobe. Same freeze-after-halt and reset rules as cycle_count.
//  Undefined: these ports and registers are absent; all other behaviour is identical.
// STRUCTURE
//  Package proc_hier_pkg: CNT_W/HIST_D defaults, 16-bit word typedef, 3-bit regid typedef.
//  Sub-module perf_counter (enable, async active-low clear, freeze, wrap) reused for cycle and perf counters.
// TESTING
//  Reset then 5 idle cycles -> cycle_count=5, fetch_stall_hist=0, counters 0.
//  wb_reg_write=1 with id_fetch_stall=1 -> reg_write=0.
//   Drop stall -> reg_write=1; write_reg=3, write_data=16'h1234 pass through.
//  m_mem_write=1, m_addr=16'h0040, m_wdata=16'hBEEF, mem_stall=1 -> mem_write=0, dcache_req=0.
//   Clear mem_stall -> both 1.
//  fetch_stall pulse 1 cycle -> hist=10'b1000000000, shifts to 10'b0000000001 after 9 more edges, then 0.
//  PROC_PERF_CNT_EN: 3 reg writes, 2 stores, halt -> inst_count=6, frozen with cycle_count.
//  Assert rst mid-count -> all state 0 asynchronously, before next clk edge.

Source files
------------

// File: rtl/proc_hier_pkg.sv
// Shared types and sizing for the proc_hier observability block.
// Counter width and stall-history depth defaults live here.
package proc_hier_pkg;
  localparam int CNT_W  = 32;
  localparam int HIST_D = 10;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  regid_t;
endpackage

// File: rtl/proc_hier_perf_counter.sv
// Free-running event counter with async active-low clear and freeze.
// Wraps modulo 2^W; used for the cycle counter and the perf counters.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_freeze,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_en && !i_freeze)
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/proc_hier_top.sv
// Trace/observability top beside core p0: qualified events, cycle count,
// fetch-stall history. PROC_PERF_CNT_EN adds the performance counters.
module proc_hier_top
  import proc_hier_pkg::*;
#(
  parameter int CNT_W  = proc_hier_pkg::CNT_W,
  parameter int HIST_D = proc_hier_pkg::HIST_D
) (
  input  logic              clk,
  input  logic              rst,
  input  word_t             pc_in,
  input  word_t             inst_in,
  input  logic              wb_reg_write,
  input  regid_t            wb_write_reg,
  input  word_t             wb_write_data,
  input  logic              id_fetch_stall,
  input  logic              wb_mem_stall,
  input  logic              fetch_stall,
  input  logic              mem_stall,
  input  logic              m_mem_read,
  input  logic              m_mem_write,
  input  word_t             m_addr,
  input  word_t             m_wdata,
  input  word_t             m_rdata,
  input  logic              icache_hit_in,
  input  logic              dcache_hit_in,
  input  logic              proc_halt,
  output word_t             pc,
  output word_t             inst,
  output logic              reg_write,
  output regid_t            write_reg,
  output word_t             write_data,
  output logic              mem_read,
  output logic              mem_write,
  output word_t             mem_addr,
  output word_t             mem_data_in,
  output word_t             mem_data_out,
  output logic              icache_req,
  output logic              icache_hit,
  output logic              dcache_req,
  output logic              dcache_hit,
  output logic              halt,
`ifdef PROC_PERF_CNT_EN
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  icache_hit_cnt,
  output logic [CNT_W-1:0]  icache_req_cnt,
  output logic [CNT_W-1:0]  dcache_hit_cnt,
  output logic [CNT_W-1:0]  dcache_req_cnt,
`endif
  output logic [CNT_W-1:0]  cycle_count,
  output logic [HIST_D-1:0] fetch_stall_hist
);
  logic              r_halted;
  logic [HIST_D-1:0] r_hist;
  logic              w_mem_ok;

  assign w_mem_ok     = ~mem_stall & ~fetch_stall;

  assign pc           = pc_in;
  assign inst         = inst_in;
  assign reg_write    = wb_reg_write & ~id_fetch_stall & ~wb_mem_stall;
  assign write_reg    = wb_write_reg;
  assign write_data   = wb_write_data;
  assign mem_read     = m_mem_read & w_mem_ok;
  assign mem_write    = m_mem_write & w_mem_ok;
  assign mem_addr     = m_addr;
  assign mem_data_in  = m_wdata;
  assign mem_data_out = m_rdata;
  assign icache_req   = ~fetch_stall;
  assign icache_hit   = icache_hit_in;
  assign dcache_req   = ~mem_stall & (m_mem_read | m_mem_write);
  assign dcache_hit   = dcache_hit_in;
  assign halt         = proc_halt;

  // Halt cycle itself is still counted; freeze starts the edge after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halted <= 1'b0;
      r_hist   <= '0;
    end else begin
      if (proc_halt)
        r_halted <= 1'b1;
      r_hist <= {fetch_stall, r_hist[HIST_D-1:1]};
    end
  end

  assign fetch_stall_hist = r_hist;

  perf_counter #(.W(CNT_W)) u_cycle (
    .clk      (clk),
    .rst_n    (rst),
    .i_en     (1'b1),
    .i_freeze (r_halted),
    .o_count  (cycle_count)
  );

`ifdef PROC_PERF_CNT_EN
  logic w_inst_ev;
  assign w_inst_ev = proc_halt | reg_write | mem_write;

  perf_counter #(.W(CNT_W)) u_inst (
    .clk(clk), .rst_n(rst), .i_en(w_inst_ev),
    .i_freeze(r_halted), .o_count(inst_count)
  );
  perf_counter #(.W(CNT_W)) u_ihit (
    .clk(clk), .rst_n(rst), .i_en(icache_hit),
    .i_freeze(r_halted), .o_count(icache_hit_cnt)
  );
  perf_counter #(.W(CNT_W)) u_ireq (
    .clk(clk), .rst_n(rst), .i_en(icache_req),
    .i_freeze(r_halted), .o_count(icache_req_cnt)
  );
  perf_counter #(.W(CNT_W)) u_dhit (
    .clk(clk), .rst_n(rst), .i_en(dcache_hit),
    .i_freeze(r_halted), .o_count(dcache_hit_cnt)
  );
  perf_counter #(.W(CNT_W)) u_dreq (
    .clk(clk), .rst_n(rst), .i_en(dcache_req),
    .i_freeze(r_halted), .o_count(dcache_req_cnt)
  );
`endif
endmodule

// File: tb/tb_proc_hier_top.sv
// Directed bench for proc_hier_top: event table, stall history,
// halt freeze and async reset. Perf checks only with PROC_PERF_CNT_EN.
module tb_proc_hier_top;
  import proc_hier_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  word_t       pc_in, inst_in, wb_write_data;
  word_t       m_addr, m_wdata, m_rdata;
  regid_t      wb_write_reg;
  logic        wb_reg_write, id_fetch_stall, wb_mem_stall;
  logic        fetch_stall, mem_stall, m_mem_read, m_mem_write;
  logic        icache_hit_in, dcache_hit_in, proc_halt;

  word_t       pc, inst, write_data, mem_addr, mem_data_in, mem_data_out;
  regid_t      write_reg;
  logic        reg_write, mem_read, mem_write;
  logic        icache_req, icache_hit, dcache_req, dcache_hit, halt;
  logic [31:0] cycle_count;
  logic [9:0]  fetch_stall_hist;
`ifdef PROC_PERF_CNT_EN
  logic [31:0] inst_count, icache_hit_cnt, icache_req_cnt;
  logic [31:0] dcache_hit_cnt, dcache_req_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_hier_top dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .inst_in(inst_in),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data),
    .id_fetch_stall(id_fetch_stall), .wb_mem_stall(wb_mem_stall),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .icache_hit_in(icache_hit_in), .dcache_hit_in(dcache_hit_in),
    .proc_halt(proc_halt),
    .pc(pc), .inst(inst), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .halt(halt),
`ifdef PROC_PERF_CNT_EN
    .inst_count(inst_count), .icache_hit_cnt(icache_hit_cnt),
    .icache_req_cnt(icache_req_cnt), .dcache_hit_cnt(dcache_hit_cnt),
    .dcache_req_cnt(dcache_req_cnt),
`endif
    .cycle_count(cycle_count), .fetch_stall_hist(fetch_stall_hist)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wb_reg_write = 0; id_fetch_stall = 0; wb_mem_stall = 0;
    fetch_stall = 0; mem_stall = 0; m_mem_read = 0; m_mem_write = 0;
    icache_hit_in = 0; dcache_hit_in = 0; proc_halt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    #1;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  typedef struct {
    string nm;
    logic  wr, ifs, wms, fs, ms, rd, wt;
    logic  e_rw, e_mr, e_mw, e_ir, e_dr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    //          nm    wr ifs wms fs ms rd wt  rw mr mw ir dr
    tbl[0] = '{"v0", 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    tbl[1] = '{"v1", 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0};
    tbl[2] = '{"v2", 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0};
    tbl[3] = '{"v3", 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 1, 0};
    tbl[4] = '{"v4", 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 1};
    tbl[5] = '{"v5", 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 1};
    tbl[6] = '{"v6", 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 1};
    tbl[7] = '{"v7", 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0};
    tbl[8] = '{"v8", 0, 0, 0, 1, 0, 1, 1,  0, 0, 0, 0, 1};
    tbl[9] = '{"v9", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0};

    rst = 0;
    idle();
    pc_in = 16'h0100; inst_in = 16'hA5C3;
    wb_write_reg = 3'd0; wb_write_data = 16'h0;
    m_addr = 16'h0; m_wdata = 16'h0; m_rdata = 16'h0;
    step(2);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_hist", {22'd0, fetch_stall_hist}, 32'd0);
    chk("rst_pc_pass", {16'd0, pc}, 32'h0100);

    rst = 1;
    step(5);
    chk("idle5_cycle", cycle_count, 32'd5);
    chk("idle5_hist", {22'd0, fetch_stall_hist}, 32'd0);
`ifdef PROC_PERF_CNT_EN
    chk("idle5_inst", inst_count, 32'd0);
    chk("idle5_dreq", dcache_req_cnt, 32'd0);
`endif

    foreach (tbl[i]) begin
      wb_reg_write = tbl[i].wr; id_fetch_stall = tbl[i].ifs;
      wb_mem_stall = tbl[i].wms; fetch_stall = tbl[i].fs;
      mem_stall = tbl[i].ms; m_mem_read = tbl[i].rd;
      m_mem_write = tbl[i].wt;
      #1;
      chk({tbl[i].nm, "_rw"}, {31'd0, reg_write}, {31'd0, tbl[i].e_rw});
      chk({tbl[i].nm, "_mr"}, {31'd0, mem_read}, {31'd0, tbl[i].e_mr});
      chk({tbl[i].nm, "_mw"}, {31'd0, mem_write}, {31'd0, tbl[i].e_mw});
      chk({tbl[i].nm, "_ir"}, {31'd0, icache_req}, {31'd0, tbl[i].e_ir});
      chk({tbl[i].nm, "_dr"}, {31'd0, dcache_req}, {31'd0, tbl[i].e_dr});
    end
    idle();

    wb_reg_write = 1; id_fetch_stall = 1;
    wb_write_reg = 3'd3; wb_write_data = 16'h1234;
    #1;
    chk("rw_stalled", {31'd0, reg_write}, 32'd0);
    id_fetch_stall = 0;
    #1;
    chk("rw_go", {31'd0, reg_write}, 32'd1);
    chk("wreg_pass", {29'd0, write_reg}, 32'd3);
    chk("wdata_pass", {16'd0, write_data}, 32'h1234);
    wb_reg_write = 0;

    m_mem_write = 1; m_addr = 16'h0040; m_wdata = 16'hBEEF;
    m_rdata = 16'h5A5A; mem_stall = 1;
    #1;
    chk("st_stall_mw", {31'd0, mem_write}, 32'd0);
    chk("st_stall_dr", {31'd0, dcache_req}, 32'd0);
    mem_stall = 0;
    #1;
    chk("st_go_mw", {31'd0, mem_write}, 32'd1);
    chk("st_go_dr", {31'd0, dcache_req}, 32'd1);
    chk("addr_pass", {16'd0, mem_addr}, 32'h0040);
    chk("wd_pass", {16'd0, mem_data_in}, 32'hBEEF);
    chk("rd_pass", {16'd0, mem_data_out}, 32'h5A5A);
    icache_hit_in = 1; dcache_hit_in = 0; proc_halt = 0;
    #1;
    chk("ihit_pass", {31'd0, icache_hit}, 32'd1);
    chk("dhit_pass", {31'd0, dcache_hit}, 32'd0);
    chk("halt_pass", {31'd0, halt}, 32'd0);
    idle();

    // Async clear mid-cycle, no clock edge between assert and check.
    @(negedge clk);
    rst = 0;
    #1;
    chk("async_cycle", cycle_count, 32'd0);
    chk("async_hist", {22'd0, fetch_stall_hist}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1;

    fetch_stall = 1;
    step(1);
    fetch_stall = 0;
    chk("hist_new", {22'd0, fetch_stall_hist}, 32'h200);
    step(9);
    chk("hist_old", {22'd0, fetch_stall_hist}, 32'h001);
    step(1);
    chk("hist_gone", {22'd0, fetch_stall_hist}, 32'd0);
    chk("cycle_11", cycle_count, 32'd11);

    do_reset();
    wb_reg_write = 1;
    step(3);
    wb_reg_write = 0; m_mem_write = 1;
    step(2);
    m_mem_write = 0; proc_halt = 1;
    step(1);
    chk("halt_cycle", cycle_count, 32'd6);
`ifdef PROC_PERF_CNT_EN
    chk("halt_inst", inst_count, 32'd6);
    chk("halt_dreq", dcache_req_cnt, 32'd2);
    chk("halt_ireq", icache_req_cnt, 32'd6);
`endif
    step(3);
    chk("frozen_cycle", cycle_count, 32'd6);
`ifdef PROC_PERF_CNT_EN
    chk("frozen_inst", inst_count, 32'd6);
`endif
    proc_halt = 0;
    step(2);
    chk("sticky_cycle", cycle_count, 32'd6);

    do_reset();
    step(2);
    chk("resume_cycle", cycle_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
